// File: rtl/motor_pkg.sv
// Shared motor-control definitions: FSM states, direction codes and H-bridge pin pairs.
package motor_pkg;

    typedef enum logic [2:0] {
        SLEEP = 3'd0,
        WAKE  = 3'd1,
        RUN   = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Pin pairs are {ain1, ain2}.
    localparam logic [1:0] COAST = 2'b00;
    localparam logic [1:0] BRAKE = 2'b11;

    // Forward chops ain1, reverse chops ain2; the idle leg stays low (coast in off-time).
    function automatic logic [1:0] drive_pins(input logic dir, input logic pwm);
        return (dir == DIR_REV) ? {1'b0, pwm} : {pwm, 1'b0};
    endfunction

endpackage

// File: rtl/hbridge_drive_if.sv
// Control/status bundle between the motor controller and the H-bridge output stage.
interface hbridge_drive_if;
    logic       pwm_in;
    logic       nsleep_in;
    logic       dir_req;
    logic       brake_req;
    logic       nfault;
    logic       fault_clr;
    logic       ain1;
    logic       ain2;
    logic       nsleep_out;
    logic       fault_o;
    logic [2:0] state_o;

    // Controller side: issues requests, observes pins and status.
    modport master (
        output pwm_in, nsleep_in, dir_req, brake_req, nfault, fault_clr,
        input  ain1, ain2, nsleep_out, fault_o, state_o
    );

    // Output stage side.
    modport slave (
        input  pwm_in, nsleep_in, dir_req, brake_req, nfault, fault_clr,
        output ain1, ain2, nsleep_out, fault_o, state_o
    );
endinterface

// File: rtl/hbridge_drive_fault_filter.sv
// Synchronizes the asynchronous driver nfault pin and declares a fault only after
// FAULT_FILT consecutive low samples, so short glitches are rejected.
module fault_filter
    import motor_pkg::*;
#(
    parameter int FAULT_FILT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nfault,
    output logic fault_det
);

    localparam int FILT_W = $clog2(FAULT_FILT + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FAULT_FILT);

    logic              sync_1;
    logic              sync_2;
    logic [FILT_W-1:0] low_cnt;

    // Two-flop synchronizer; idles high so reset never looks like a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= nfault;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive low samples, saturating; any high sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt <= '0;
        end else if (sync_2) begin
            low_cnt <= '0;
        end else if (low_cnt != FILT_MAX) begin
            low_cnt <= low_cnt + FILT_W'(1);
        end
    end

    assign fault_det = (low_cnt == FILT_MAX);

endmodule

// File: rtl/hbridge_drive.sv
// H-bridge output stage: turns PWM, direction, brake and sleep requests into the
// driver pin pair and nsleep, with wake delay, reversal dead time and latched fault.
module hbridge_drive
    import motor_pkg::*;
#(
    parameter int WAKE_CYCLES = 100000,
    parameter int DEAD_CYCLES = 2000,
    parameter int FAULT_FILT  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hbridge_drive_if.slave bus
);

    localparam int CNT_MAX = (WAKE_CYCLES > DEAD_CYCLES) ? WAKE_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    logic [1:0]       rst_sync;
    logic             rst_int;
    logic             fault_det;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_cur;
    logic [1:0]       pins;
    logic             nsleep_r;
    logic             fault_r;

    // Reset asserts immediately but releases two clocks later, clean of rst_n timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    fault_filter #(
        .FAULT_FILT (FAULT_FILT)
    ) u_fault_filter (
        .clk       (clk),
        .rst_n     (rst_int),
        .nfault    (bus.nfault),
        .fault_det (fault_det)
    );

    // Main FSM: fault beats sleep beats normal sequencing; every output is registered here.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state    <= SLEEP;
            cnt      <= '0;
            dir_cur  <= DIR_FWD;
            pins     <= COAST;
            nsleep_r <= 1'b0;
            fault_r  <= 1'b0;
        end else if (fault_det) begin
            // A live fault also overrides a simultaneous fault_clr.
            state    <= FAULT;
            cnt      <= '0;
            pins     <= COAST;
            nsleep_r <= 1'b0;
            fault_r  <= 1'b1;
        end else if (state == FAULT) begin
            // Latched: only an explicit clear with the pin healthy leaves FAULT.
            pins     <= COAST;
            nsleep_r <= 1'b0;
            if (bus.fault_clr) begin
                state   <= SLEEP;
                fault_r <= 1'b0;
            end
        end else if (!bus.nsleep_in) begin
            state    <= SLEEP;
            cnt      <= '0;
            pins     <= COAST;
            nsleep_r <= 1'b0;
        end else begin
            unique case (state)
                SLEEP: begin
                    state    <= WAKE;
                    cnt      <= WAKE_LOAD;
                    pins     <= COAST;
                    nsleep_r <= 1'b1;
                end
                WAKE: begin
                    pins     <= COAST;
                    nsleep_r <= 1'b1;
                    if (cnt == '0) begin
                        state   <= RUN;
                        dir_cur <= bus.dir_req;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    nsleep_r <= 1'b1;
                    if (bus.brake_req) begin
                        // Braking already has both high sides off, so direction may change freely.
                        pins    <= BRAKE;
                        dir_cur <= bus.dir_req;
                    end else if (bus.dir_req != dir_cur) begin
                        state <= DEAD;
                        cnt   <= DEAD_LOAD;
                        pins  <= COAST;
                    end else begin
                        pins <= drive_pins(dir_cur, bus.pwm_in);
                    end
                end
                DEAD: begin
                    nsleep_r <= 1'b1;
                    if (cnt == '0) begin
                        // Drive on the exit edge so exactly DEAD_CYCLES coast cycles are seen.
                        state   <= RUN;
                        dir_cur <= bus.dir_req;
                        pins    <= drive_pins(bus.dir_req, bus.pwm_in);
                    end else begin
                        cnt  <= cnt - CNT_W'(1);
                        pins <= COAST;
                    end
                end
                default: begin
                    state    <= SLEEP;
                    cnt      <= '0;
                    pins     <= COAST;
                    nsleep_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ain1       = pins[1];
    assign bus.ain2       = pins[0];
    assign bus.nsleep_out = nsleep_r;
    assign bus.fault_o    = fault_r;
    assign bus.state_o    = state;

endmodule

// File: doc/hbridge_drive.md
# hbridge_drive

Output stage placed directly after the PWM speed generator. It converts the single-ended `pwm_in` and sleep request into the two-input H-bridge pin pair plus the driver `nsleep` pin. Its jobs are:
- direction control, braking and coasting;
- a wake-up delay after sleep exit;
- a coast dead interval on every direction reversal;
- a filtered, latched response to the driver's `nfault` pin.

## Interface
- `WAKE_CYCLES`, 100000: cycles from `nsleep_out` rising to bridge enable (1 ms at 100 MHz).
- `DEAD_CYCLES`, 2000: coast cycles inserted on direction reversal (one PWM period).
- `FAULT_FILT`, 16: consecutive synchronized-low cycles of `nfault` required to declare a fault.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  PWM from the speed stage; synchronous to `clk`.
- `nsleep_in`  in  1  1 = driver requested awake.
- `dir_req`  in  1  0 = forward, 1 = reverse.
- `brake_req`  in  1  1 = short-brake both low-side legs.
- `nfault`  in  1  driver fault pin, active-low, asynchronous.
- `fault_clr`  in  1  single-cycle pulse that clears a latched fault.
- `ain1`, `ain2`  out  1 each  bridge inputs.
- `nsleep_out`  out  1  driver sleep pin, active-low sleep.
- `fault_o`  out  1  latched fault flag.
- `state_o`  out  3  current FSM state encoding, for debug.

## Operation
- **Reset** (async assert, sync deassert internally):
  - state = SLEEP;
  - `ain1` = `ain2` = 0, `nsleep_out` = 0, `fault_o` = 0;
  - `dir_cur` = 0, counter = 0.
- **Pin decode**:
  - coast = 00;
  - forward = {`pwm_in`, 0};
  - reverse = {0, `pwm_in`};
  - brake = 11.
- **SLEEP**:
  - `nsleep_out` = 0, pins = coast.
  - Exit to WAKE when `nsleep_in` = 1 and no filtered fault; the counter loads `WAKE_CYCLES`-1.
- **WAKE**:
  - `nsleep_out` = 1, pins = coast.
  - The counter decrements each cycle. At 0: go to RUN and set `dir_cur` ← `dir_req`.
- **RUN**:
  - `nsleep_out` = 1.
  - If `brake_req` = 1: pins = brake, and `dir_cur` tracks `dir_req` with no dead interval.
  - Else if `dir_req` ≠ `dir_cur`: go to DEAD and load `DEAD_CYCLES`-1.
  - Else: pins = decode(`dir_cur`).
- **DEAD**:
  - pins = coast; the counter decrements.
  - At 0: go to RUN with `dir_cur` ← `dir_req` sampled at exit. If the request toggled back, the old direction resumes with no further dead time.
  - `brake_req` during DEAD is ignored until RUN.
- **FAULT**:
  - pins = coast, `nsleep_out` = 0, `fault_o` = 1.
  - Exit to SLEEP only when `fault_clr` = 1 and filtered `nfault` = 1. `fault_clr` while the fault persists is ignored.
- **Priority**, evaluated every cycle from any state:
  1. filtered fault → FAULT;
  2. `nsleep_in` = 0 → SLEEP (aborts WAKE/DEAD mid-count; counter cleared);
  3. normal transitions.
- **Fault filter**:
  - `nfault` passes through a 2-flop synchronizer.
  - The filter counter increments while the synchronized value = 0 and saturates at `FAULT_FILT`. It clears on any synchronized 1.
  - Fault is declared when the count reaches `FAULT_FILT`.
  - Glitches shorter than `FAULT_FILT` cycles have no effect.
- **Counter width**: $clog2 of max(`WAKE_CYCLES`, `DEAD_CYCLES`).
- **Filter width**: $clog2(`FAULT_FILT`+1).

## Timing
- All outputs are registered.
- `ain1`/`ain2` follow `pwm_in` with exactly 1 cycle latency in RUN; no combinational path from input to output.
- `nsleep_out` rises 1 cycle after the SLEEP→WAKE decision. The first non-coast pin state appears `WAKE_CYCLES`+1 cycles after `nsleep_in` is sampled high.
- Reversal: the last old-direction pin value is followed by exactly `DEAD_CYCLES` coast cycles, then the new direction.
- Fault: pins are coast and `nsleep_out` = 0 at most `FAULT_FILT`+3 cycles after the `nfault` falling edge.
- A `nsleep_in` fall forces `nsleep_out` = 0 and coast on the next edge.
- Simultaneous fault and `fault_clr`: fault wins, and the state remains FAULT.

## Structure
- **Shared package `motor_pkg`**:
  - state enum: SLEEP, WAKE, RUN, DEAD, FAULT;
  - direction constants DIR_FWD = 0, DIR_REV = 1;
  - pin-pair constants COAST, BRAKE.
  - The speed stage reuses the package.
- **One sub-module `fault_filter`**:
  - 2-flop synchronizer plus saturating low-count;
  - parameter `FAULT_FILT`; output `fault_det`.
- The top contains the FSM, the shared down-counter and the output decode registers.

## Test plan
All scenarios use `WAKE_CYCLES`=10, `DEAD_CYCLES`=5, `FAULT_FILT`=4.
1. **Reset and wake**: `rst_n` low, then `nsleep_in`=1, `pwm_in`=1, `dir_req`=0 → `nsleep_out`=1 next cycle; `ain1`=1, `ain2`=0 first seen 11 cycles after `nsleep_in` is sampled; all outputs 0 during reset.
2. **Reversal**: in RUN forward, `pwm_in` toggling, set `dir_req`=1 → exactly 5 cycles of `ain`=00, then `ain2` follows `pwm_in` one cycle delayed and `ain1`=0. Toggle `dir_req` back inside DEAD → forward resumes after the same 5 cycles.
3. **Brake**: `brake_req`=1 in RUN → `ain`=11 next cycle. Change `dir_req` while braking, release brake → new direction immediately, no coast.
4. **Fault filter**: `nfault` low 3 cycles → no effect. Low 10 cycles → `fault_o`=1, `ain`=00, `nsleep_out`=0 within 7 cycles. `fault_clr` while low → stays FAULT. Release `nfault`, pulse `fault_clr` → SLEEP, then WAKE if `nsleep_in`=1.
5. **Sleep abort**: drop `nsleep_in` at WAKE count 5 → SLEEP, `nsleep_out`=0 next edge. Reassert → full 10-cycle wake restarts.
6. **Async reset mid-DEAD**: `rst_n` low asynchronously → outputs 0 immediately without a clock edge; state_o = SLEEP.
